// File: rtl/display_ctrl_pkg.sv
// ============================================================================
// Module   : display_ctrl_pkg
// Purpose  : Shared state encoding, message codes and switch classification
//            for the front-panel display scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [3:0] MSG_NONE   = 4'd0;
    localparam logic [3:0] MSG_ERR    = 4'd15;
    localparam int         NUM_DIGITS = 4;

    // No switch -> none, exactly one switch -> its index + 1, otherwise error.
    function automatic logic [3:0] classify_sel(input logic [7:0] pat);
        logic [3:0] ones;
        logic [3:0] idx;
        ones = 4'd0;
        idx  = MSG_NONE;
        for (int i = 0; i < 8; i++) begin
            if (pat[i]) begin
                ones = ones + 4'd1;
                idx  = 4'(i + 1);
            end
        end
        if (ones == 4'd0) begin
            return MSG_NONE;
        end else if (ones == 4'd1) begin
            return idx;
        end else begin
            return MSG_ERR;
        end
    endfunction

    function automatic state_t msg_state(input logic [3:0] msg);
        if (msg == MSG_NONE) begin
            return ST_IDLE;
        end else if (msg == MSG_ERR) begin
            return ST_ERROR;
        end else begin
            return ST_SHOW;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_controller_prescaler.sv
// ============================================================================
// Module   : scan_prescaler
// Purpose  : Free-running divider producing a one-cycle tick every SCAN_DIV
//            clocks; the first tick is consumed SCAN_DIV edges after reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/display_scan_controller.sv
// ============================================================================
// Module   : display_scan_controller
// Purpose  : Scans the four-digit panel display and arbitrates the eight
//            selection switches into one debounced message ID.
//            Optional macro DISPLAY_ERR_BLINK_EN blinks the error message in
//            alternate 16-tick windows.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_controller
    import display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int STABLE_TICKS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    sel_in,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_cnt,
    output logic [NUM_DIGITS-1:0]         digit_en_n,
    output logic [3:0]                    msg_id,
    output logic                          msg_valid,
    output logic                          err
);

    localparam int                    SCAN_W    = $clog2(NUM_DIGITS);
    localparam logic [3:0]            C_STABLE  = 4'(STABLE_TICKS);
    localparam logic [NUM_DIGITS-1:0] C_DIGIT0  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [NUM_DIGITS-1:0] C_ALL_OFF = '1;

    logic [7:0]        r_sync1;
    logic [7:0]        r_sync2;
    logic [7:0]        r_prev_pat;
    logic [7:0]        r_committed;
    logic [3:0]        r_stable;
    state_t            r_state;

    logic              w_tick;
    logic [3:0]        w_stable_nx;
    logic              w_commit;
    logic [3:0]        w_cls;
    logic              w_msg_change;
    logic [3:0]        w_msg_nx;
    state_t            w_state_nx;
    logic [SCAN_W-1:0] w_scan_nx;
    logic              w_lit;
    logic              w_dark;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Switches are asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sel_in;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_stable_nx = 4'd1;
        if (r_sync2 == r_prev_pat) begin
            w_stable_nx = (r_stable >= C_STABLE) ? C_STABLE : r_stable + 4'd1;
        end
        w_commit     = (w_stable_nx == C_STABLE) && (r_sync2 != r_committed);
        w_cls        = classify_sel(r_sync2);
        // Two different multi-switch patterns both map to the error code and
        // must not re-blank the display.
        w_msg_change = w_commit && (w_cls != msg_id);
        w_msg_nx     = w_msg_change ? w_cls : msg_id;

        w_state_nx = r_state;
        if (w_msg_change) begin
            w_state_nx = ST_BLANK;
        end else if (r_state == ST_BLANK) begin
            w_state_nx = msg_state(msg_id);
        end

        w_scan_nx = scan_cnt + 1'b1;
        w_lit     = (w_state_nx == ST_SHOW) || (w_state_nx == ST_ERROR);
    end

`ifdef DISPLAY_ERR_BLINK_EN
    logic [4:0] r_blink;
    logic [4:0] w_blink_nx;

    always_comb begin
        w_blink_nx = 5'd0;
        if ((r_state == ST_ERROR) && (w_state_nx == ST_ERROR)) begin
            w_blink_nx = r_blink + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= 5'd0;
        end else if (w_tick) begin
            r_blink <= w_blink_nx;
        end
    end

    // The first 16 ticks of every 32-tick window in ERROR are dark.
    assign w_dark = (w_state_nx == ST_ERROR) && !w_blink_nx[4];
`else
    assign w_dark = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_pat  <= '0;
            r_committed <= '0;
            r_stable    <= 4'd0;
            r_state     <= ST_IDLE;
            scan_cnt    <= '0;
            digit_en_n  <= C_ALL_OFF;
            msg_id      <= MSG_NONE;
            msg_valid   <= 1'b0;
            err         <= 1'b0;
        end else if (w_tick) begin
            r_prev_pat <= r_sync2;
            r_stable   <= w_stable_nx;
            if (w_commit) begin
                r_committed <= r_sync2;
            end
            r_state    <= w_state_nx;
            scan_cnt   <= w_scan_nx;
            msg_id     <= w_msg_nx;
            msg_valid  <= (w_state_nx == ST_SHOW);
            err        <= (w_state_nx == ST_ERROR);
            digit_en_n <= (w_lit && !w_dark) ? ~(C_DIGIT0 << w_scan_nx) : C_ALL_OFF;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_controller.sv
// ============================================================================
// Module   : tb_display_scan_controller
// Purpose  : Randomised scoreboard bench for display_scan_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan_controller;

    localparam int N  = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sel_in;
    logic [1:0] scan_cnt;
    logic [3:0] digit_en_n;
    logic [3:0] msg_id;
    logic       msg_valid;
    logic       err;

    display_scan_controller #(
        .SCAN_DIV     (N),
        .STABLE_TICKS (ST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_in     (sel_in),
        .scan_cnt   (scan_cnt),
        .digit_en_n (digit_en_n),
        .msg_id     (msg_id),
        .msg_valid  (msg_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] scan;
        logic [3:0] den;
        logic [3:0] msg;
        logic       valid;
        logic       err;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: plain counts of ticks and edges.
    int         edge_n;
    logic [7:0] d1, d2;
    logic [7:0] m_prev, m_committed;
    int         m_stable, m_msg, m_scan, m_err_age;
    bit         m_blank, m_prev_shown_err;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic obs_t now_obs();
        obs_t o;
        o.scan  = scan_cnt;
        o.den   = digit_en_n;
        o.msg   = msg_id;
        o.valid = msg_valid;
        o.err   = err;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o.scan  = 2'd0;
        o.den   = 4'hF;
        o.msg   = 4'd0;
        o.valid = 1'b0;
        o.err   = 1'b0;
        return o;
    endfunction

    function automatic int msg_of(input logic [7:0] p);
        int ones;
        int idx;
        ones = 0;
        idx  = 0;
        for (int i = 0; i < 8; i++) begin
            if (p[i]) begin
                ones++;
                idx = i + 1;
            end
        end
        if (ones == 0) return 0;
        if (ones == 1) return idx;
        return 15;
    endfunction

    task automatic model_reset();
        edge_n = 0; d1 = '0; d2 = '0;
        m_prev = '0; m_committed = '0;
        m_stable = 0; m_msg = 0; m_scan = 0; m_err_age = 0;
        m_blank = 1'b0; m_prev_shown_err = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge: the DUT acts on the switch value seen two edges ago.
    task automatic step();
        logic [7:0] cand;
        obs_t       e;
        bit         shown_err;
        bit         lit;
        @(posedge clk);
        edge_n++;
        cand = d2;
        d2   = d1;
        d1   = sel_in;
        if (edge_n % N == 0) begin
            m_scan = (m_scan + 1) % 4;
            m_stable = (cand == m_prev) ? ((m_stable < ST) ? m_stable + 1 : ST) : 1;
            m_prev  = cand;
            m_blank = 1'b0;
            if (m_stable == ST && cand != m_committed) begin
                m_committed = cand;
                if (msg_of(cand) != m_msg) begin
                    m_msg   = msg_of(cand);
                    m_blank = 1'b1;
                end
            end
            shown_err = !m_blank && (m_msg == 15);
            if (shown_err) m_err_age = m_prev_shown_err ? m_err_age + 1 : 0;
            m_prev_shown_err = shown_err;
            lit = !m_blank && (m_msg != 0);
`ifdef DISPLAY_ERR_BLINK_EN
            if (shown_err && ((m_err_age / 16) % 2 == 0)) lit = 1'b0;
`endif
            e.scan  = 2'(m_scan);
            e.msg   = 4'(m_msg);
            e.valid = !m_blank && (m_msg >= 1) && (m_msg <= 8);
            e.err   = shown_err;
            e.den   = lit ? ~(4'b0001 << m_scan) : 4'hF;
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic hold(input logic [7:0] pat, input int cycles);
        sel_in = pat;
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, "_scan_cnt"}, scan_cnt, 0);
        check({tag, "_digit_en_n"}, digit_en_n, 15);
        check({tag, "_msg_id"}, msg_id, 0);
        check({tag, "_msg_valid"}, msg_valid, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_now("midreset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: every change on the outputs must match the next model entry.
    initial begin
        obs_t last;
        obs_t cur;
        obs_t e;
        last = reset_obs();
        forever begin
            @(negedge clk);
            cur = now_obs();
            if (!rst_n) begin
                last = reset_obs();
            end else if (cur != last) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", int'(cur), int'(last));
                end else begin
                    e = exp_q.pop_front();
                    check("scan_cnt", cur.scan, e.scan);
                    check("digit_en_n", cur.den, e.den);
                    check("msg_id", cur.msg, e.msg);
                    check("msg_valid", cur.valid, e.valid);
                    check("err", cur.err, e.err);
                end
                last = cur;
            end
        end
    end

    initial begin
        logic [7:0] pat;
        rst_n  = 1'b1;
        sel_in = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_reset_now("reset");
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        hold(8'h00, 40);
        hold(8'h02, 40);
        hold(8'h06, 40);
        hold(8'h02, 40);
        hold(8'h03, 5);
        hold(8'h02, 30);
        pulse_reset();
        hold(8'h02, 10);
        hold(8'h00, 40);
        hold(8'h01, 5);
        hold(8'h00, 30);
        hold(8'h06, 300);
        hold(8'h05, 60);
        hold(8'h80, 60);

        pat = 8'h00;
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 3))
                0: pat = 8'h00;
                1: pat = 8'(1 << $urandom_range(0, 7));
                2: pat = 8'($urandom);
                default: pat = pat ^ 8'(1 << $urandom_range(0, 7));
            endcase
            hold(pat, $urandom_range(1, 50));
            if (s == 30) pulse_reset();
        end
        hold(8'h00, 60);

        @(negedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
